// File: rtl/bsg_rr_arb_idx_reg_if.sv
// Handshake bundle between requesters, the round-robin arbiter and the
// downstream one-hot index decoder.
interface bsg_rr_arb_idx_reg_if #(
  parameter int inputs_p    = 16,
  parameter int lg_inputs_p = $clog2(inputs_p)
);
  logic [inputs_p-1:0]    reqs_i;
  logic [inputs_p-1:0]    yumi_o;
  logic                   v_o;
  logic [lg_inputs_p-1:0] idx_o;
  logic                   ready_i;

  // master: requester/consumer side driving the arbiter
  modport master (output reqs_i, ready_i, input yumi_o, v_o, idx_o);
  modport slave  (input reqs_i, ready_i, output yumi_o, v_o, idx_o);
endinterface

// File: rtl/bsg_rr_arb_idx_reg.sv
// Registered round-robin arbiter: picks one requester per cycle with rotating
// priority and holds the winner's binary index in a single-entry output register.
module bsg_rr_arb_idx_reg #(
  parameter int inputs_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_rr_arb_idx_reg_if.slave     arb
);
  localparam int lg_inputs_p = $clog2(inputs_p);
  localparam logic [lg_inputs_p-1:0] LastIdx = lg_inputs_p'(inputs_p - 1);

  logic                   v_q, v_d;
  logic [lg_inputs_p-1:0] idx_q, idx_d;
  logic [lg_inputs_p-1:0] last_q, last_d;

  logic                     load_en, any_req, grant;
  logic [lg_inputs_p-1:0]   start, off, win_idx;
  logic [2*inputs_p-1:0]    dbl, dbl_sh;
  logic [inputs_p-1:0]      rot;

  assign load_en = ~v_q | arb.ready_i;
  assign any_req = |arb.reqs_i;
  // reset gating keeps yumi quiet while the register is forced empty
  assign grant   = load_en & any_req & reset_n_i;

  // Rotate so the scan start lands at bit 0; power-of-two width makes the
  // index arithmetic wrap for free.
  assign start  = last_q + 1'b1;
  assign dbl    = {arb.reqs_i, arb.reqs_i};
  assign dbl_sh = dbl >> start;
  assign rot    = dbl_sh[inputs_p-1:0];

  always_comb begin
    off = '0;
    for (int k = inputs_p - 1; k >= 0; k--)
      if (rot[k]) off = k[lg_inputs_p-1:0];
  end

  assign win_idx = start + off;

  for (genvar k = 0; k < inputs_p; k++) begin : g_yumi
    localparam logic [lg_inputs_p-1:0] K = lg_inputs_p'(k);
    assign arb.yumi_o[k] = grant & (win_idx == K);
  end

  always_comb begin
    v_d    = v_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (load_en) begin
      v_d = any_req;
      if (any_req) begin
        idx_d  = win_idx;
        last_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      idx_q  <= '0;
      last_q <= LastIdx;
    end else begin
      v_q    <= v_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign arb.v_o   = v_q;
  assign arb.idx_o = idx_q;
endmodule

// File: tb/tb_bsg_rr_arb_idx_reg.sv
// Directed bench for the registered round-robin index arbiter; inputs change on
// the falling edge and outputs are sampled 1 ns later.
module tb_bsg_rr_arb_idx_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nassert = 0;
  int   nfail = 0;

  bsg_rr_arb_idx_reg_if #(.inputs_p(16)) arb_if ();

  bsg_rr_arb_idx_reg #(.inputs_p(16)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .arb       (arb_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] reqs, input logic rdy);
    @(negedge clk);
    arb_if.reqs_i  = reqs;
    arb_if.ready_i = rdy;
    #1;
  endtask

  initial begin
    arb_if.reqs_i  = 16'hFFFF;
    arb_if.ready_i = 1'b1;

    // reset held with every request up
    repeat (3) step(16'hFFFF, 1'b1);
    chk("rst_v", 32'(arb_if.v_o), 32'h0);
    chk("rst_idx", 32'(arb_if.idx_o), 32'h0);
    chk("rst_yumi", 32'(arb_if.yumi_o), 32'h0);

    // release, then 20 cycles of full load
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_v", 32'(arb_if.v_o), 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step(16'hFFFF, 1'b1);
      chk($sformatf("rot_yumi%0d", i), 32'(arb_if.yumi_o), 32'(1) << (i % 16));
      if (i > 0) begin
        chk($sformatf("rot_v%0d", i), 32'(arb_if.v_o), 32'h1);
        chk($sformatf("rot_idx%0d", i), 32'(arb_if.idx_o), 32'((i - 1) % 16));
      end
    end

    // park winner 5 in the register
    step(16'h0020, 1'b1);
    chk("rot_idx_last", 32'(arb_if.idx_o), 32'h3);
    chk("bp_yumi5", 32'(arb_if.yumi_o), 32'h0020);

    // backpressure: index and yumi frozen
    for (int i = 0; i < 3; i++) begin
      step(16'h0240, 1'b0);
      chk($sformatf("bp_v%0d", i), 32'(arb_if.v_o), 32'h1);
      chk($sformatf("bp_idx%0d", i), 32'(arb_if.idx_o), 32'h5);
      chk($sformatf("bp_yumi%0d", i), 32'(arb_if.yumi_o), 32'h0);
    end
    step(16'h0240, 1'b1);
    chk("bp_rel_yumi", 32'(arb_if.yumi_o), 32'h0040);
    step(16'h0200, 1'b1);
    chk("bp_idx6", 32'(arb_if.idx_o), 32'h6);
    chk("bp_yumi9", 32'(arb_if.yumi_o), 32'h0200);

    // wrap-around from last winner 14
    step(16'h4000, 1'b1);
    chk("bp_idx9", 32'(arb_if.idx_o), 32'h9);
    chk("wr_yumi14", 32'(arb_if.yumi_o), 32'h4000);
    step(16'h8003, 1'b1);
    chk("wr_idx14", 32'(arb_if.idx_o), 32'hE);
    chk("wr_yumi15", 32'(arb_if.yumi_o), 32'h8000);
    step(16'h8003, 1'b1);
    chk("wr_idx15", 32'(arb_if.idx_o), 32'hF);
    chk("wr_yumi0", 32'(arb_if.yumi_o), 32'h0001);
    step(16'h8003, 1'b1);
    chk("wr_idx0", 32'(arb_if.idx_o), 32'h0);
    chk("wr_yumi1", 32'(arb_if.yumi_o), 32'h0002);

    // sparse single pulse on requester 11
    step(16'h0800, 1'b1);
    chk("wr_idx1", 32'(arb_if.idx_o), 32'h1);
    chk("sp_yumi", 32'(arb_if.yumi_o), 32'h0800);
    step(16'h0000, 1'b1);
    chk("sp_v", 32'(arb_if.v_o), 32'h1);
    chk("sp_idx", 32'(arb_if.idx_o), 32'hB);
    chk("sp_yumi0", 32'(arb_if.yumi_o), 32'h0);
    step(16'h0000, 1'b1);
    chk("sp_drain_v", 32'(arb_if.v_o), 32'h0);

    // mid-operation reset with index 7 pending
    step(16'h0080, 1'b1);
    chk("mr_yumi7", 32'(arb_if.yumi_o), 32'h0080);
    step(16'h0180, 1'b0);
    chk("mr_v", 32'(arb_if.v_o), 32'h1);
    chk("mr_idx", 32'(arb_if.idx_o), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_v", 32'(arb_if.v_o), 32'h0);
    chk("mr_rst_idx", 32'(arb_if.idx_o), 32'h0);
    chk("mr_rst_yumi", 32'(arb_if.yumi_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    arb_if.ready_i = 1'b1;
    #1;
    chk("mr_rel_yumi", 32'(arb_if.yumi_o), 32'h0080);
    step(16'h0100, 1'b1);
    chk("mr_rel_v", 32'(arb_if.v_o), 32'h1);
    chk("mr_rel_idx", 32'(arb_if.idx_o), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
